// File: rtl/counter_mod_pkg.sv
// Shared constants for the modulus up/down counter.
// The optional saturate mode is enabled with the COUNTER_MOD_SAT_EN macro.
package counter_mod_pkg;

    localparam int   DEFAULT_WIDTH = 4;
    localparam logic DIR_UP        = 1'b1;
    localparam logic DIR_DOWN      = 1'b0;

endpackage

// File: rtl/counter_mod_step.sv
// Combinational next-count and wrap flag for one enabled counting step.
// The sat_i input is tied low by the top unless COUNTER_MOD_SAT_EN is defined.
module counter_mod_step
    import counter_mod_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic [WIDTH-1:0] limit_i,
    input  logic             up_i,
    input  logic             sat_i,
    output logic [WIDTH-1:0] next_o,
    output logic             wrap_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        next_o = count_i;
        wrap_o = 1'b0;
        if (up_i == DIR_UP) begin
            if (count_i >= limit_i) begin
                next_o = sat_i ? limit_i : '0;
                wrap_o = !sat_i;
            end else begin
                next_o = count_i + ONE;
            end
        end else begin
            if (count_i == '0) begin
                next_o = sat_i ? '0 : limit_i;
                wrap_o = !sat_i;
            end else if (count_i > limit_i) begin
                // Out-of-range count after a limit shrink snaps to the new top quietly.
                next_o = limit_i;
            end else begin
                next_o = count_i - ONE;
            end
        end
    end

endmodule

// File: rtl/counter_mod.sv
// Up/down modulus counter with programmable limit, parallel load and wrap pulse.
// Defining COUNTER_MOD_SAT_EN adds the sat port for saturating behaviour.
module counter_mod
    import counter_mod_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RST_LIMIT = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             limit_wr,
    input  logic [WIDTH-1:0] limit_val,
`ifdef COUNTER_MOD_SAT_EN
    input  logic             sat,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap_p
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] step_next;
    logic             step_wrap;
    logic             sat_w;

`ifdef COUNTER_MOD_SAT_EN
    assign sat_w = sat;
`else
    assign sat_w = 1'b0;
`endif

    counter_mod_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .count_i (count_q),
        .limit_i (limit_q),
        .up_i    (up),
        .sat_i   (sat_w),
        .next_o  (step_next),
        .wrap_o  (step_wrap)
    );

    // The count update always sees limit_q, so a same-cycle limit write lands one edge later.
    always_comb begin
        count_d = count_q;
        limit_d = limit_q;
        wrap_d  = 1'b0;
        if (limit_wr) begin
            limit_d = limit_val;
        end
        if (load) begin
            count_d = (load_val < limit_q) ? load_val : limit_q;
        end else if (en) begin
            count_d = step_next;
            wrap_d  = step_wrap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            limit_q <= RST_LIMIT;
            wrap_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            count_q <= count_d;
            limit_q <= limit_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count  = count_q;
    assign wrap_p = wrap_q;
    assign tc     = ((up == DIR_UP) && (count_q == limit_q)) ||
                    ((up == DIR_DOWN) && (count_q == '0));

endmodule

// File: tb/tb_counter_mod.sv
// Scoreboard bench for counter_mod: driver pushes model predictions, monitor compares per edge.
// Saturate-mode stimulus is compiled in only when COUNTER_MOD_SAT_EN is defined.
module tb_counter_mod;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         en = 1'b0;
    logic         up = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         limit_wr = 1'b0;
    logic [W-1:0] limit_val = '0;
    logic         sat = 1'b0;
    logic [W-1:0] count;
    logic         tc;
    logic         wrap_p;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int cnt;
        int wrap;
        int tc;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: plain integers following the counting rules.
    int  m_cnt = 0;
    int  m_lim = 15;
    bit  sat_mode = 1'b0;

    counter_mod #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .up        (up),
        .load      (load),
        .load_val  (load_val),
        .limit_wr  (limit_wr),
        .limit_val (limit_val),
`ifdef COUNTER_MOD_SAT_EN
        .sat       (sat),
`endif
        .count     (count),
        .tc        (tc),
        .wrap_p    (wrap_p)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drives one cycle from a negedge, predicts the post-edge outputs, then drops the strobes.
    task automatic drive(input bit e, input bit u, input bit ld, input int lval,
                         input bit lw, input int lv);
        exp_t x;
        int   nxt;
        int   w;
        @(negedge clk);
        en        = e;
        up        = u;
        load      = ld;
        load_val  = lval[W-1:0];
        limit_wr  = lw;
        limit_val = lv[W-1:0];
        sat       = sat_mode;
        nxt = m_cnt;
        w   = 0;
        if (ld) begin
            nxt = (lval < m_lim) ? lval : m_lim;
        end else if (e) begin
            if (u) begin
                if (m_cnt >= m_lim) begin
                    if (sat_mode) nxt = m_lim;
                    else begin nxt = 0; w = 1; end
                end else begin
                    nxt = m_cnt + 1;
                end
            end else if (m_cnt == 0) begin
                if (!sat_mode) begin nxt = m_lim; w = 1; end
            end else if (m_cnt > m_lim) begin
                nxt = m_lim;
            end else begin
                nxt = m_cnt - 1;
            end
        end
        if (lw) m_lim = lv;
        m_cnt = nxt;
        x.cnt  = m_cnt;
        x.wrap = w;
        x.tc   = ((u && m_cnt == m_lim) || (!u && m_cnt == 0)) ? 1 : 0;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        en       = 1'b0;
        load     = 1'b0;
        limit_wr = 1'b0;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("count", int'(count), x.cnt);
                check("wrap_p", int'(wrap_p), x.wrap);
                check("tc", int'(tc), x.tc);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: bench did not finish, %0d predictions pending", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        // Asynchronous reset before any clock edge.
        #3 rst_n = 1'b0;
        #1;
        check("reset_count", int'(count), 0);
        check("reset_wrap", int'(wrap_p), 0);
        check("reset_tc", int'(tc), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Full count to the default limit and wrap.
        for (int i = 0; i < 17; i++) drive(1, 1, 0, 0, 0, 0);

        // Limit 9: count up through the wrap, then turn around at 0.
        while (m_cnt != 0) drive(1, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 1, 9);
        for (int i = 0; i < 10; i++) drive(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0);

        // Load clamping and load overriding en.
        drive(0, 1, 1, 12, 0, 0);
        drive(1, 1, 1, 3, 0, 0);

        // Shrinking the limit under a count of 12.
        drive(0, 1, 0, 0, 1, 15);
        drive(0, 1, 1, 12, 0, 0);
        drive(0, 1, 0, 0, 1, 9);
        drive(1, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 1, 15);
        drive(0, 0, 1, 12, 0, 0);
        drive(0, 0, 0, 0, 1, 9);
        drive(1, 0, 0, 0, 0, 0);
        // Limit write alongside en: old limit applies to this step.
        drive(0, 1, 0, 0, 1, 15);
        drive(0, 1, 1, 12, 0, 0);
        drive(1, 1, 0, 0, 1, 9);
        drive(1, 1, 0, 0, 0, 0);

`ifdef COUNTER_MOD_SAT_EN
        sat_mode = 1'b1;
        drive(0, 1, 1, 7, 1, 9);
        for (int i = 0; i < 5; i++) drive(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) drive(1, 0, 0, 0, 0, 0);
        sat_mode = 1'b0;
        drive(0, 1, 0, 0, 0, 0);
`endif

        // Reset between edges at count 7 with limit 9.
        drive(0, 1, 1, 7, 1, 9);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_count", int'(count), 0);
        check("midreset_wrap", int'(wrap_p), 0);
        m_cnt = 0;
        m_lim = 15;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, 0, 0, 0, 0);

        // Reset while a wrap pulse is high discards it.
        while (m_cnt != 15) drive(1, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("reset_drops_wrap", int'(wrap_p), 0);
        m_cnt = 0;
        m_lim = 15;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 9) == 0), int'($urandom_range(0, 15)),
                  ($urandom_range(0, 11) == 0), int'($urandom_range(0, 15)));
        end

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
